// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, ID/EX and write-back bundles, and the all-zero bubble
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam int ALUOP_W = 4;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
  } id_ex_t;
  typedef struct packed {
    logic reg_write;
    logic [4:0] rd;
    logic [XLEN-1:0] data;
  } wb_t;
  localparam id_ex_t BUBBLE = '0;
endpackage

// File: rtl/id_ex_pipe_reg_hazard_detect.sv
// hazard_detect: combinational load-use compare of the ID instruction against the load sitting in ID/EX
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       id_use_rs1,
  input  logic [4:0] id_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rs2,
  input  logic       ex_flush,
  output logic       load_use_stall
);
  assign load_use_stall = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                          ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd))) & ~ex_flush;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX register with load-use bubble, flush, global stall and a one-cycle write-back shadow.
//   in : id_* decoded fields/operands, ex_flush, ext_stall, wb_* write-back port
//   out: ID_EX_* registered fields, WB_*_reg delayed write-back, load_use_stall (comb)
module id_ex_pipe_reg
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic               id_RegWrite,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_MemtoReg,
  input  logic               id_ALUSrc,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic               ex_flush,
  input  logic               ext_stall,
  input  logic               wb_RegWrite,
  input  logic [4:0]         wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic               ID_EX_valid,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_MemtoReg,
  output logic               ID_EX_ALUSrc,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic [4:0]         ID_EX_rs1,
  output logic [4:0]         ID_EX_rs2,
  output logic [4:0]         ID_EX_rd,
  output logic [XLEN-1:0]    ID_EX_pc,
  output logic [XLEN-1:0]    ID_EX_imm,
  output logic [XLEN-1:0]    ID_EX_rs1_data,
  output logic [XLEN-1:0]    ID_EX_rs2_data,
  output logic               WB_RegWrite_reg,
  output logic [4:0]         WB_rd_reg,
  output logic [XLEN-1:0]    WB_data_reg,
  output logic               load_use_stall
);
  id_ex_t id_ex_q, id_ex_d, id_cap;
  wb_t wb_q, wb_d;
  hazard_detect u_hazard (
    .ex_valid(id_ex_q.valid),
    .ex_mem_read(id_ex_q.mem_read),
    .ex_rd(id_ex_q.rd),
    .id_valid(id_valid),
    .id_use_rs1(id_use_rs1),
    .id_rs1(id_rs1),
    .id_use_rs2(id_use_rs2),
    .id_rs2(id_rs2),
    .ex_flush(ex_flush),
    .load_use_stall(load_use_stall)
  );
  assign id_cap = '{valid: 1'b1, reg_write: id_RegWrite, mem_read: id_MemRead, mem_write: id_MemWrite,
                    mem_to_reg: id_MemtoReg, alu_src: id_ALUSrc, alu_op: id_ALUOp, rs1: id_rs1,
                    rs2: id_rs2, rd: id_rd, pc: id_pc, imm: id_imm, rs1_data: id_rs1_data,
                    rs2_data: id_rs2_data};
  // ext_stall outranks flush: EX re-raises ex_flush once the stall clears
  always_comb begin
    id_ex_d = ext_stall ? id_ex_q : (ex_flush | load_use_stall | ~id_valid) ? BUBBLE : id_cap;
    wb_d = ext_stall ? wb_q : '{reg_write: wb_RegWrite & (wb_rd != 5'd0), rd: wb_rd, data: wb_data};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q <= BUBBLE;
      wb_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
      wb_q <= wb_d;
    end
  end
  assign ID_EX_valid = id_ex_q.valid;
  assign ID_EX_RegWrite = id_ex_q.reg_write;
  assign ID_EX_MemRead = id_ex_q.mem_read;
  assign ID_EX_MemWrite = id_ex_q.mem_write;
  assign ID_EX_MemtoReg = id_ex_q.mem_to_reg;
  assign ID_EX_ALUSrc = id_ex_q.alu_src;
  assign ID_EX_ALUOp = id_ex_q.alu_op;
  assign ID_EX_rs1 = id_ex_q.rs1;
  assign ID_EX_rs2 = id_ex_q.rs2;
  assign ID_EX_rd = id_ex_q.rd;
  assign ID_EX_pc = id_ex_q.pc;
  assign ID_EX_imm = id_ex_q.imm;
  assign ID_EX_rs1_data = id_ex_q.rs1_data;
  assign ID_EX_rs2_data = id_ex_q.rs2_data;
  assign WB_RegWrite_reg = wb_q.reg_write;
  assign WB_rd_reg = wb_q.rd;
  assign WB_data_reg = wb_q.data;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;
  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc;
  logic [3:0] id_ALUOp;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic ex_flush, ext_stall, wb_RegWrite;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic ID_EX_valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc;
  logic [3:0] ID_EX_ALUOp;
  logic [4:0] ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic [31:0] ID_EX_pc, ID_EX_imm, ID_EX_rs1_data, ID_EX_rs2_data;
  logic WB_RegWrite_reg;
  logic [4:0] WB_rd_reg;
  logic [31:0] WB_data_reg;
  logic load_use_stall;
  int passed = 0;
  int total = 0;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
    .id_pc(id_pc), .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .ex_flush(ex_flush), .ext_stall(ext_stall), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ID_EX_valid(ID_EX_valid), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_ALUSrc(ID_EX_ALUSrc),
    .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_pc(ID_EX_pc), .ID_EX_imm(ID_EX_imm), .ID_EX_rs1_data(ID_EX_rs1_data),
    .ID_EX_rs2_data(ID_EX_rs2_data), .WB_RegWrite_reg(WB_RegWrite_reg), .WB_rd_reg(WB_rd_reg),
    .WB_data_reg(WB_data_reg), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic rw, input logic mr, input logic [31:0] pc);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2;
    id_RegWrite = rw; id_MemRead = mr; id_MemtoReg = mr; id_MemWrite = 1'b0; id_ALUSrc = mr;
    id_ALUOp = 4'h2; id_pc = pc; id_imm = pc + 32'h4; id_rs1_data = 32'hA000_0000 | pc;
    id_rs2_data = 32'hB000_0000 | pc;
  endtask

  initial begin
    rst_n = 1'b0;
    {id_valid, id_use_rs1, id_use_rs2, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc} = 8'($urandom);
    {id_rs1, id_rs2, id_rd, id_ALUOp} = 19'($urandom);
    id_pc = $urandom; id_imm = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
    ex_flush = 1'($urandom); ext_stall = 1'($urandom);
    wb_RegWrite = 1'b1; wb_rd = 5'd7; wb_data = $urandom;
    repeat (3) tick();
    chk("rst_valid", ID_EX_valid, 0);
    chk("rst_rd", ID_EX_rd, 0);
    chk("rst_ctrl", {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_ALUOp}, 0);
    chk("rst_data", {ID_EX_pc, ID_EX_rs1_data}, 0);
    chk("rst_wb", {WB_RegWrite_reg, WB_rd_reg, WB_data_reg}, 0);
    chk("rst_stall", load_use_stall, 0);
    ex_flush = 0; ext_stall = 0; wb_RegWrite = 0; wb_rd = 0; wb_data = 0;
    instr(1, 5'd1, 5'd2, 5'd5, 1, 1, 1, 0, 32'h100);
    #2 rst_n = 1'b1;
    tick();
    chk("first_valid", ID_EX_valid, 1);
    chk("first_rd", ID_EX_rd, 5);
    chk("first_pc", ID_EX_pc, 32'h100);
    chk("first_imm", ID_EX_imm, 32'h104);
    chk("first_rs2_data", ID_EX_rs2_data, 32'hB000_0100);
    instr(1, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 32'h104);
    tick();
    chk("lw_memread", ID_EX_MemRead, 1);
    instr(1, 5'd5, 5'd7, 5'd6, 1, 1, 1, 0, 32'h108);
    #1 chk("lu_stall", load_use_stall, 1);
    tick();
    chk("lu_bubble_valid", ID_EX_valid, 0);
    chk("lu_bubble_fields", {ID_EX_MemRead, ID_EX_RegWrite, ID_EX_rd, ID_EX_rs1, ID_EX_pc}, 0);
    chk("lu_one_cycle", load_use_stall, 0);
    tick();
    chk("lu_recap_rs1", ID_EX_rs1, 5);
    chk("lu_recap_rd", ID_EX_rd, 6);
    chk("lu_recap_valid", ID_EX_valid, 1);
    instr(1, 5'd3, 5'd4, 5'd0, 1, 1, 1, 1, 32'h10C);
    tick();
    instr(1, 5'd0, 5'd0, 5'd9, 1, 1, 1, 0, 32'h110);
    #1 chk("rd0_no_stall", load_use_stall, 0);
    instr(1, 5'd3, 5'd4, 5'd5, 1, 0, 1, 1, 32'h114);
    tick();
    instr(1, 5'd3, 5'd5, 5'd8, 1, 0, 1, 0, 32'h118);
    #1 chk("nors2_no_stall", load_use_stall, 0);
    tick();
    chk("nors2_capture_rd", ID_EX_rd, 8);
    chk("nors2_capture_rs2", ID_EX_rs2, 5);
    instr(1, 5'd1, 5'd2, 5'd5, 1, 0, 1, 1, 32'h11C);
    tick();
    instr(1, 5'd5, 5'd5, 5'd6, 1, 1, 1, 0, 32'h120);
    #1 chk("pre_flush_stall", load_use_stall, 1);
    ex_flush = 1;
    #1 chk("flush_beats_lu", load_use_stall, 0);
    tick();
    chk("flush_valid", ID_EX_valid, 0);
    chk("flush_rd", ID_EX_rd, 0);
    ex_flush = 0;
    instr(1, 5'd1, 5'd2, 5'd10, 1, 1, 1, 0, 32'h200);
    wb_RegWrite = 1; wb_rd = 5'd9; wb_data = 32'hDEADBEEF;
    tick();
    chk("shadow_we", WB_RegWrite_reg, 1);
    chk("shadow_rd", WB_rd_reg, 9);
    chk("shadow_data", WB_data_reg, 32'hDEADBEEF);
    chk("pre_stall_rd", ID_EX_rd, 10);
    ext_stall = 1; ex_flush = 1;
    wb_RegWrite = 1; wb_rd = 5'd3; wb_data = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      instr(1, 5'd4, 5'd6, 5'(11 + i), 1, 1, 1, 1, 32'h300 + 32'(i));
      tick();
      chk("stall_hold_id", {ID_EX_valid, ID_EX_rd, ID_EX_pc, ID_EX_MemRead}, {1'b1, 5'd10, 32'h200, 1'b0});
      chk("stall_hold_wb", {WB_RegWrite_reg, WB_rd_reg, WB_data_reg}, {1'b1, 5'd9, 32'hDEADBEEF});
    end
    ext_stall = 0; ex_flush = 0;
    tick();
    chk("post_stall_rd", ID_EX_rd, 13);
    chk("post_stall_pc", ID_EX_pc, 32'h302);
    chk("post_stall_wb_rd", WB_rd_reg, 3);
    chk("post_stall_wb_data", WB_data_reg, 32'h1234);
    wb_RegWrite = 1; wb_rd = 5'd0; wb_data = 32'h55;
    instr(0, 5'd1, 5'd2, 5'd7, 1, 1, 1, 0, 32'h400);
    tick();
    chk("wb_rd0_we", WB_RegWrite_reg, 0);
    chk("invalid_bubble", {ID_EX_valid, ID_EX_rd, ID_EX_pc}, 0);
    instr(1, 5'd1, 5'd2, 5'd12, 1, 1, 1, 0, 32'h500);
    tick();
    chk("refill_rd", ID_EX_rd, 12);
    ext_stall = 1;
    #2 rst_n = 1'b0;
    #1 chk("async_rst_mid_stall", {ID_EX_valid, ID_EX_rd, ID_EX_pc}, 0);
    chk("async_rst_wb", {WB_RegWrite_reg, WB_rd_reg, WB_data_reg}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
